crc_ser_tx_scheduler: RTL and testbench

- Round-robin scheduler that shares one CRC + serializer packet path between NUM_REQ requesters.
- Arbitrates among requesters and latches the winner's 32-bit payload and mode.
- Sequences the path: CRC load, CRC-done wait, serializer-done wait, then returns a one-cycle ack.
- Sits in the CRC/SER clock domain, between requesting logic and the CRC/SER datapath; guards each wait with a timeout.

---
 rtl/crc_ser_tx_scheduler.sv | 152 +++++++++++++++
 tb/tb_crc_ser_tx_scheduler.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc_ser_tx_scheduler.sv
`timescale 1ns/1ps
// Round-robin scheduler sharing one CRC + serializer packet path among NUM_REQ requesters.
// Sequences load, CRC-done wait and serializer-done wait, with a timeout guard on each wait.
module crc_ser_tx_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_payload,
  input  logic [NUM_REQ-1:0]        req_mode,
  output logic [NUM_REQ-1:0]        ack,
  output logic [NUM_REQ-1:0]        grant,
  output logic [DATA_W-1:0]         dp_payload,
  output logic                      dp_mode,
  output logic                      crc_enable,
  output logic                      crc_load,
  input  logic                      crc_done,
  input  logic                      ser_done,
  output logic                      busy,
  output logic                      err,
  output logic [2:0]                err_id,
  output logic [15:0]               tx_count
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOAD     = 3'd1;
  localparam logic [2:0] S_CRC_WAIT = 3'd2;
  localparam logic [2:0] S_SER_WAIT = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;
  localparam logic [2:0] S_ABORT    = 3'd5;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  logic [2:0]         state;
  logic [2:0]         rr_ptr;
  logic [2:0]         gnt_idx;
  logic [15:0]        to_cnt;
  logic               to_hit;
  logic [7:0]         req_ext;
  logic [2:0]         sel_idx;
  logic               sel_valid;
  logic [NUM_REQ-1:0] sel_onehot;
  logic [DATA_W-1:0]  sel_payload;
  logic               sel_mode;
  logic [2:0]         next_ptr;

  function automatic logic [2:0] wrap_idx(input logic [3:0] v);
    return (v >= 4'(NUM_REQ)) ? 3'(v - 4'(NUM_REQ)) : v[2:0];
  endfunction

  always_comb begin
    req_ext = '0;
    req_ext[NUM_REQ-1:0] = req;
  end

  // Search downward so the offset closest to rr_ptr is the last (winning) assignment.
  always_comb begin
    sel_idx   = '0;
    sel_valid = 1'b0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      if (req_ext[wrap_idx({1'b0, rr_ptr} + 4'(off))]) begin
        sel_idx   = wrap_idx({1'b0, rr_ptr} + 4'(off));
        sel_valid = 1'b1;
      end
    end
  end

  always_comb begin
    sel_onehot  = '0;
    sel_payload = '0;
    sel_mode    = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (3'(i) == sel_idx) begin
        sel_onehot[i] = 1'b1;
        sel_payload   = req_payload[i*DATA_W +: DATA_W];
        sel_mode      = req_mode[i];
      end
    end
  end

  assign next_ptr = wrap_idx({1'b0, gnt_idx} + 4'd1);
  assign to_hit   = (to_cnt == TO_LAST);

  // Done ticks are tested before the timeout so a coincident done wins.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= S_IDLE;
      rr_ptr     <= '0;
      gnt_idx    <= '0;
      grant      <= '0;
      dp_payload <= '0;
      dp_mode    <= 1'b0;
      err_id     <= '0;
      tx_count   <= '0;
      to_cnt     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (sel_valid) begin
            grant      <= sel_onehot;
            gnt_idx    <= sel_idx;
            dp_payload <= sel_payload;
            dp_mode    <= sel_mode;
            state      <= S_LOAD;
          end
        end
        S_LOAD: begin
          to_cnt <= '0;
          state  <= S_CRC_WAIT;
        end
        S_CRC_WAIT: begin
          if (crc_done) begin
            to_cnt <= '0;
            state  <= S_SER_WAIT;
          end else if (to_hit) begin
            err_id <= gnt_idx;
            state  <= S_ABORT;
          end else begin
            to_cnt <= to_cnt + 16'd1;
          end
        end
        S_SER_WAIT: begin
          if (ser_done) begin
            tx_count <= tx_count + 16'd1;
            state    <= S_DONE;
          end else if (to_hit) begin
            err_id <= gnt_idx;
            state  <= S_ABORT;
          end else begin
            to_cnt <= to_cnt + 16'd1;
          end
        end
        S_DONE, S_ABORT: begin
          grant  <= '0;
          rr_ptr <= next_ptr;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign crc_load   = (state == S_LOAD);
  assign crc_enable = (state == S_LOAD) || (state == S_CRC_WAIT);
  assign busy       = (state != S_IDLE);
  assign err        = (state == S_ABORT);
  assign ack        = (state == S_DONE) ? grant : '0;

endmodule

// File: tb/tb_crc_ser_tx_scheduler.sv
`timescale 1ns/1ps
// Directed scoreboard bench for crc_ser_tx_scheduler: a default-timeout instance for normal
// traffic and a TIMEOUT=16 instance for the abort and done-at-the-limit cases.
module tb_crc_ser_tx_scheduler;
  localparam int NR = 4;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstn;
  logic [NR-1:0] req, req_t;
  logic [NR*DW-1:0] payload;
  logic [NR-1:0] mode;
  logic          crc_done, ser_done;

  logic [NR-1:0] ack, grant;
  logic [DW-1:0] dp_payload;
  logic          dp_mode, crc_enable, crc_load, busy, err;
  logic [2:0]    err_id;
  logic [15:0]   tx_count;

  logic [NR-1:0] t_ack, t_grant;
  logic [DW-1:0] t_dp_payload;
  logic          t_dp_mode, t_crc_enable, t_crc_load, t_busy, t_err;
  logic [2:0]    t_err_id;
  logic [15:0]   t_tx_count;

  crc_ser_tx_scheduler #(.NUM_REQ(NR), .DATA_W(DW), .TIMEOUT(255)) dut (
    .clk(clk), .rstn(rstn), .req(req), .req_payload(payload), .req_mode(mode),
    .ack(ack), .grant(grant), .dp_payload(dp_payload), .dp_mode(dp_mode),
    .crc_enable(crc_enable), .crc_load(crc_load), .crc_done(crc_done), .ser_done(ser_done),
    .busy(busy), .err(err), .err_id(err_id), .tx_count(tx_count)
  );

  crc_ser_tx_scheduler #(.NUM_REQ(NR), .DATA_W(DW), .TIMEOUT(16)) dut16 (
    .clk(clk), .rstn(rstn), .req(req_t), .req_payload(payload), .req_mode(mode),
    .ack(t_ack), .grant(t_grant), .dp_payload(t_dp_payload), .dp_mode(t_dp_mode),
    .crc_enable(t_crc_enable), .crc_load(t_crc_load), .crc_done(crc_done), .ser_done(ser_done),
    .busy(t_busy), .err(t_err), .err_id(t_err_id), .tx_count(t_tx_count)
  );

  typedef struct {
    logic [NR-1:0] ack;
    logic [DW-1:0] payload;
    logic          mode;
  } exp_t;

  exp_t sb_q[$];
  int vectors = 0;
  int miscompares = 0;
  int m_rr = 0;
  int exp_tx = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic applyStimulus(input int idx, input logic [31:0] pl, input logic md);
    payload[idx*DW +: DW] = pl;
    mode[idx] = md;
    req[idx]  = 1'b1;
  endtask

  // Round-robin reference: first set request at or after m_rr, modulo NR.
  task automatic push_expected(output int idx);
    exp_t e;
    idx = -1;
    for (int off = 0; off < NR; off++) begin
      int c;
      c = (m_rr + off) % NR;
      if (idx < 0 && req[c]) idx = c;
    end
    if (idx < 0) idx = 0;
    e.ack     = 4'b0001 << idx;
    e.payload = payload[idx*DW +: DW];
    e.mode    = mode[idx];
    sb_q.push_back(e);
    m_rr = (idx + 1) % NR;
  endtask

  task automatic service(input int crc_dly, input int ser_dly, input bit corrupt);
    int n = 0;
    while (crc_load !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    checkOutput("crc_load_seen", 32'(crc_load), 1);
    step();
    checkOutput("crc_load_pulse", 32'(crc_load), 0);
    checkOutput("crc_wait_enable", 32'(crc_enable), 1);
    if (corrupt) begin
      payload[DW-1:0] = ~payload[DW-1:0];
      mode[0] = ~mode[0];
    end
    repeat (crc_dly - 1) step();
    crc_done = 1'b1;
    step();
    crc_done = 1'b0;
    checkOutput("ser_wait_enable", 32'(crc_enable), 0);
    repeat (ser_dly - 1) step();
    ser_done = 1'b1;
    step();
    ser_done = 1'b0;
  endtask

  task automatic scoreboard_check();
    exp_t e;
    checkOutput("sb_pending", 32'(sb_q.size() > 0), 1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      exp_tx++;
      checkOutput("ack", 32'(ack), 32'(e.ack));
      checkOutput("grant", 32'(grant), 32'(e.ack));
      checkOutput("dp_payload", dp_payload, e.payload);
      checkOutput("dp_mode", 32'(dp_mode), 32'(e.mode));
      checkOutput("tx_count", 32'(tx_count), 32'(exp_tx));
      checkOutput("err_on_done", 32'(err), 0);
    end
    step();
    checkOutput("ack_pulse", 32'(ack), 0);
    checkOutput("idle_gap", 32'(busy), 0);
  endtask

  initial begin
    int idx;
    rstn = 1'b0; req = '0; req_t = '0; payload = '0; mode = '0;
    crc_done = 1'b0; ser_done = 1'b0;
    step();
    step();
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_grant", 32'(grant), 0);
    checkOutput("rst_ack", 32'(ack), 0);
    checkOutput("rst_crc_load", 32'(crc_load), 0);
    checkOutput("rst_crc_enable", 32'(crc_enable), 0);
    checkOutput("rst_err", 32'(err), 0);
    checkOutput("rst_err_id", 32'(err_id), 0);
    checkOutput("rst_dp_payload", dp_payload, 0);
    checkOutput("rst_dp_mode", 32'(dp_mode), 0);
    checkOutput("rst_tx_count", 32'(tx_count), 0);
    checkOutput("rst_t_busy", 32'(t_busy), 0);
    rstn = 1'b1;
    step();

    $display("[TB] single request");
    applyStimulus(0, 32'hDEADBEEF, 1'b1);
    push_expected(idx);
    step();
    checkOutput("t1_crc_load", 32'(crc_load), 1);
    checkOutput("t1_grant", 32'(grant), 'h1);
    checkOutput("t1_dp_payload", dp_payload, 32'hDEADBEEF);
    checkOutput("t1_dp_mode", 32'(dp_mode), 1);
    req = '0;
    service(5, 40, 1'b0);
    scoreboard_check();

    $display("[TB] round-robin fairness");
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    m_rr = 0;
    exp_tx = 0;
    step();
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < NR; i++)
        applyStimulus(i, 32'hA000_0000 | (pass << 8) | i, 1'(i ^ pass));
      for (int k = 0; k < NR; k++) begin
        push_expected(idx);
        service(1, 1, 1'b0);
        scoreboard_check();
        req[idx] = 1'b0;
      end
    end
    checkOutput("t2_tx_count", 32'(tx_count), 8);

    $display("[TB] crc timeout");
    req_t = 4'b0100;
    step();
    checkOutput("t3_grant", 32'(t_grant), 'h4);
    checkOutput("t3_crc_load", 32'(t_crc_load), 1);
    req_t = '0;
    step();
    checkOutput("t3_crc_enable", 32'(t_crc_enable), 1);
    repeat (15) step();
    checkOutput("t3_no_early_err", 32'(t_err), 0);
    checkOutput("t3_busy", 32'(t_busy), 1);
    step();
    checkOutput("t3_err", 32'(t_err), 1);
    checkOutput("t3_err_id", 32'(t_err_id), 2);
    checkOutput("t3_no_ack", 32'(t_ack), 0);
    checkOutput("t3_tx_count", 32'(t_tx_count), 0);
    checkOutput("t3_grant_held", 32'(t_grant), 'h4);
    req_t = 4'b1111;
    step();
    checkOutput("t3_err_pulse", 32'(t_err), 0);
    checkOutput("t3_err_id_held", 32'(t_err_id), 2);
    checkOutput("t3_grant_clr", 32'(t_grant), 0);
    step();
    checkOutput("t3_next_grant", 32'(t_grant), 'h8);
    req_t = '0;

    $display("[TB] done at timeout boundary");
    step();
    crc_done = 1'b1;
    step();
    crc_done = 1'b0;
    checkOutput("t4_ser_wait", 32'(t_crc_enable), 0);
    repeat (14) step();
    checkOutput("t4_no_early_err", 32'(t_err), 0);
    step();
    ser_done = 1'b1;
    step();
    ser_done = 1'b0;
    checkOutput("t4_ack", 32'(t_ack), 'h8);
    checkOutput("t4_err", 32'(t_err), 0);
    checkOutput("t4_tx_count", 32'(t_tx_count), 1);
    step();
    checkOutput("t4_ack_pulse", 32'(t_ack), 0);
    checkOutput("t4_err_after", 32'(t_err), 0);
    checkOutput("t4_idle", 32'(t_busy), 0);

    $display("[TB] reset mid-packet");
    applyStimulus(1, 32'h5555AAAA, 1'b0);
    step();
    req = '0;
    step();
    crc_done = 1'b1;
    step();
    crc_done = 1'b0;
    checkOutput("t5_busy_before", 32'(busy), 1);
    checkOutput("t5_tx_before", 32'(tx_count), 8);
    rstn = 1'b0;
    step();
    checkOutput("t5_busy", 32'(busy), 0);
    checkOutput("t5_grant", 32'(grant), 0);
    checkOutput("t5_tx_count", 32'(tx_count), 0);
    checkOutput("t5_ack", 32'(ack), 0);
    checkOutput("t5_dp_payload", dp_payload, 0);
    rstn = 1'b1;
    m_rr = 0;
    exp_tx = 0;
    applyStimulus(3, 32'hC0FFEE03, 1'b1);
    push_expected(idx);
    service(2, 3, 1'b0);
    scoreboard_check();
    req = '0;

    $display("[TB] req dropped and payload changed after grant");
    applyStimulus(0, 32'h12345678, 1'b0);
    push_expected(idx);
    step();
    req = '0;
    service(3, 2, 1'b1);
    scoreboard_check();

    checkOutput("sb_drained", 32'(sb_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
